// File: rtl/stream_pkg.sv
// Helpers shared by the AXI-Stream adapters.
package stream_pkg;

  // Round a bit count up to a whole number of bytes.
  function automatic int byte_pad(input int bits);
    return ((bits + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/stream_pe_dwc.sv
// Repacks AXI-Stream beats of IN_PE elements into beats of OUT_PE elements, element 0 in the LSBs and first in time.
// Latency 1 cycle in all modes; output_tvalid is registered and input_tready drops only when buffered data cannot drain.
module stream_pe_dwc
  import stream_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int IN_PE      = 4,
  parameter int OUT_PE     = 2,
  localparam int IBITS     = byte_pad(IN_PE * ELEM_WIDTH),
  localparam int OBITS     = byte_pad(OUT_PE * ELEM_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             input_tready,
  input  logic             input_tvalid,
  input  logic [IBITS-1:0] input_tdata,
  input  logic             output_tready,
  output logic             output_tvalid,
  output logic [OBITS-1:0] output_tdata
);

  localparam int R  = (IN_PE > OUT_PE) ? IN_PE / OUT_PE : OUT_PE / IN_PE;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam int IW = IN_PE * ELEM_WIDTH;
  localparam int OW = OUT_PE * ELEM_WIDTH;

  typedef logic [IN_PE-1:0][ELEM_WIDTH-1:0]  in_elems_t;
  typedef logic [OUT_PE-1:0][ELEM_WIDTH-1:0] out_elems_t;

  in_elems_t  in_elems;
  out_elems_t out_elems;
  logic       in_fire;
  logic       unused_pad;

  if (ELEM_WIDTH < 1 || (IN_PE % OUT_PE != 0 && OUT_PE % IN_PE != 0)) begin : g_bad_cfg
    $error("stream_pe_dwc: IN_PE=%0d and OUT_PE=%0d must be integer multiples", IN_PE, OUT_PE);
  end

  assign in_elems     = input_tdata[IW-1:0];
  assign unused_pad   = ^input_tdata;
  assign in_fire      = input_tvalid && input_tready;
  assign output_tdata = OBITS'(out_elems);

  if (IN_PE > OUT_PE) begin : g_down
    in_elems_t     hold;
    logic          full;
    logic [CW-1:0] idx;
    logic          last;
    logic [IW-1:0] shifted;

    assign last          = (idx == CW'(R - 1));
    // The next beat may only enter while the final slice of the current one leaves.
    assign input_tready  = !rst && (!full || (output_tready && last));
    assign shifted       = hold >> (OW * int'(idx));
    assign out_elems     = shifted[OW-1:0];
    assign output_tvalid = full;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold <= '0;
        full <= 1'b0;
        idx  <= '0;
      end else if (in_fire) begin
        hold <= in_elems;
        full <= 1'b1;
        idx  <= '0;
      end else if (full && output_tready) begin
        if (last) full <= 1'b0;
        else      idx  <= idx + 1'b1;
      end
    end

  end else if (OUT_PE > IN_PE) begin : g_up
    out_elems_t    acc;
    out_elems_t    acc_next;
    out_elems_t    oreg;
    logic          ovld;
    logic [CW-1:0] cnt;
    logic          last;
    logic [OW-1:0] lane_mask;
    logic [OW-1:0] lane_data;

    assign last          = (cnt == CW'(R - 1));
    // Only the completing beat needs the output register free.
    assign input_tready  = !rst && !(last && ovld && !output_tready);
    assign lane_mask     = OW'({IW{1'b1}}) << (IW * int'(cnt));
    assign lane_data     = OW'(in_elems) << (IW * int'(cnt));
    assign acc_next      = (acc & ~lane_mask) | lane_data;
    assign out_elems     = oreg;
    assign output_tvalid = ovld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc  <= '0;
        oreg <= '0;
        ovld <= 1'b0;
        cnt  <= '0;
      end else begin
        if (in_fire) begin
          acc <= acc_next;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        if (in_fire && last) begin
          oreg <= acc_next;
          ovld <= 1'b1;
        end else if (output_tready) begin
          ovld <= 1'b0;
        end
      end
    end

  end else begin : g_equal
    out_elems_t oreg;
    logic       ovld;

    assign input_tready  = !rst && (!ovld || output_tready);
    assign out_elems     = oreg;
    assign output_tvalid = ovld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        oreg <= '0;
        ovld <= 1'b0;
      end else if (in_fire) begin
        oreg <= in_elems;
        ovld <= 1'b1;
      end else if (output_tready) begin
        ovld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_pe_dwc.sv
// Bench for stream_pe_dwc: directed corner cases plus random streams for down/up/odd/equal configurations.
module tb_stream_pe_dwc;

  localparam int N = 4;
  localparam int EWS  [N] = '{4, 4, 3, 8};
  localparam int IPES [N] = '{4, 2, 3, 2};
  localparam int OPES [N] = '{2, 4, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld  [N];
  logic        in_rdy  [N];
  logic        out_vld [N];
  logic        out_rdy [N];
  logic [15:0] in_dat  [N];
  logic [15:0] out_dat [N];
  logic [7:0]  od0, od2;
  logic [15:0] od1, od3;

  int tests = 0;
  int fails = 0;
  int cur = 0;
  int cyc = 0;
  int first_in = -1;
  int last_out = -1;
  logic [15:0] obsq[$];
  logic [15:0] sentq[$];

  always #5 clk = ~clk;

  stream_pe_dwc #(.ELEM_WIDTH(4), .IN_PE(4), .OUT_PE(2)) dut_down (
    .clk(clk), .rst(rst),
    .input_tready(in_rdy[0]), .input_tvalid(in_vld[0]), .input_tdata(in_dat[0]),
    .output_tready(out_rdy[0]), .output_tvalid(out_vld[0]), .output_tdata(od0));

  stream_pe_dwc #(.ELEM_WIDTH(4), .IN_PE(2), .OUT_PE(4)) dut_up (
    .clk(clk), .rst(rst),
    .input_tready(in_rdy[1]), .input_tvalid(in_vld[1]), .input_tdata(in_dat[1][7:0]),
    .output_tready(out_rdy[1]), .output_tvalid(out_vld[1]), .output_tdata(od1));

  stream_pe_dwc #(.ELEM_WIDTH(3), .IN_PE(3), .OUT_PE(1)) dut_odd (
    .clk(clk), .rst(rst),
    .input_tready(in_rdy[2]), .input_tvalid(in_vld[2]), .input_tdata(in_dat[2]),
    .output_tready(out_rdy[2]), .output_tvalid(out_vld[2]), .output_tdata(od2));

  stream_pe_dwc #(.ELEM_WIDTH(8), .IN_PE(2), .OUT_PE(2)) dut_eq (
    .clk(clk), .rst(rst),
    .input_tready(in_rdy[3]), .input_tvalid(in_vld[3]), .input_tdata(in_dat[3]),
    .output_tready(out_rdy[3]), .output_tvalid(out_vld[3]), .output_tdata(od3));

  assign out_dat[0] = {8'h00, od0};
  assign out_dat[1] = od1;
  assign out_dat[2] = {8'h00, od2};
  assign out_dat[3] = od3;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor for the configuration currently under test.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_vld[cur] && in_rdy[cur] && first_in < 0) first_in = cyc;
      if (out_vld[cur] && out_rdy[cur]) begin
        obsq.push_back(out_dat[cur]);
        last_out = cyc;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic run_stream(input int k, input int n, input int vpct, input int rpct);
    bit acc = 1'b0;
    int sent = 0;
    int guard = 0;
    int nout = n * IPES[k] / OPES[k];
    cur = k;
    sentq.delete();
    obsq.delete();
    first_in = -1;
    last_out = -1;
    while ((sent < n || obsq.size() < nout) && guard < 5000) begin
      tick();
      guard++;
      if (acc) begin
        sent++;
        in_vld[k] = 1'b0;
      end
      if (!in_vld[k] && sent < n && $urandom_range(99) < vpct) begin
        in_vld[k] = 1'b1;
        in_dat[k] = 16'($urandom);
      end
      out_rdy[k] = ($urandom_range(99) < rpct);
      smp();
      acc = in_vld[k] && in_rdy[k];
      if (acc) sentq.push_back(in_dat[k]);
    end
    in_vld[k]  = 1'b0;
    out_rdy[k] = 1'b0;
  endtask

  // Reference: flatten accepted beats into an element stream, regroup OUT_PE at a time.
  task automatic check_run(input string tag, input int k, input int n, input bit span);
    int elems[$];
    int nout = n * IPES[k] / OPES[k];
    int minpe = (IPES[k] < OPES[k]) ? IPES[k] : OPES[k];
    int word;
    chk({tag, " beats"}, sentq.size(), n);
    chk({tag, " words"}, obsq.size(), nout);
    foreach (sentq[i])
      for (int e = 0; e < IPES[k]; e++)
        elems.push_back((int'(sentq[i]) >> (e * EWS[k])) & ((1 << EWS[k]) - 1));
    for (int w = 0; w < nout && w < obsq.size() && (w + 1) * OPES[k] <= elems.size(); w++) begin
      word = 0;
      for (int j = 0; j < OPES[k]; j++) word |= elems[w * OPES[k] + j] << (j * EWS[k]);
      chk($sformatf("%s word%0d", tag, w), obsq[w], word);
    end
    if (span) chk({tag, " span"}, last_out - first_in, n * IPES[k] / minpe);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      in_vld[k]  = 1'b0;
      in_dat[k]  = '0;
      out_rdy[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) smp();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst in_rdy%0d", k), in_rdy[k], 0);
      chk($sformatf("rst out_vld%0d", k), out_vld[k], 0);
      chk($sformatf("rst out_dat%0d", k), out_dat[k], 0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("release in_rdy%0d", k), in_rdy[k], 1);

    // Downsize 4->2: one beat, two slices on consecutive cycles.
    cur = 0;
    tick(); in_vld[0] = 1'b1; in_dat[0] = 16'h4321; out_rdy[0] = 1'b1;
    smp();  chk("dn accept rdy", in_rdy[0], 1); chk("dn pre vld", out_vld[0], 0);
    tick(); in_vld[0] = 1'b0;
    smp();  chk("dn s0 vld", out_vld[0], 1); chk("dn s0 dat", out_dat[0], 16'h21);
    tick(); smp(); chk("dn s1 vld", out_vld[0], 1); chk("dn s1 dat", out_dat[0], 16'h43);
    tick(); smp(); chk("dn drained", out_vld[0], 0);

    // Downsize backpressure on slice 1 with the next beat waiting.
    tick(); in_vld[0] = 1'b1; in_dat[0] = 16'h8765;
    smp();
    tick(); in_dat[0] = 16'hCBA9;
    smp();  chk("bp s0 dat", out_dat[0], 16'h65); chk("bp s0 in_rdy", in_rdy[0], 0);
    tick(); out_rdy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk($sformatf("bp stall%0d dat", c), out_dat[0], 16'h87);
      chk($sformatf("bp stall%0d vld", c), out_vld[0], 1);
      chk($sformatf("bp stall%0d in_rdy", c), in_rdy[0], 0);
      tick();
    end
    out_rdy[0] = 1'b1;
    smp();  chk("bp release in_rdy", in_rdy[0], 1); chk("bp release dat", out_dat[0], 16'h87);
    tick(); in_vld[0] = 1'b0;
    smp();  chk("bp next s0", out_dat[0], 16'hA9);
    tick(); smp(); chk("bp next s1", out_dat[0], 16'hCB);
    tick(); smp(); chk("bp drained", out_vld[0], 0);

    // Upsize 2->4: two beats form one word.
    cur = 1; out_rdy[1] = 1'b1;
    tick(); in_vld[1] = 1'b1; in_dat[1] = 16'h0021;
    smp();  chk("up rdy", in_rdy[1], 1);
    tick(); in_dat[1] = 16'h0043;
    smp();  chk("up mid vld", out_vld[1], 0);
    tick(); in_vld[1] = 1'b0;
    smp();  chk("up word vld", out_vld[1], 1); chk("up word dat", out_dat[1], 16'h4321);
    tick(); smp(); chk("up drained", out_vld[1], 0);

    // Upsize reset with a held word and a half-built word.
    out_rdy[1] = 1'b0;
    tick(); in_vld[1] = 1'b1; in_dat[1] = 16'h0087;
    tick(); in_dat[1] = 16'h00A9;
    tick(); in_dat[1] = 16'h0065;
    tick(); in_vld[1] = 1'b0;
    smp();  chk("up held vld", out_vld[1], 1); chk("up held dat", out_dat[1], 16'hA987);
    tick(); rst = 1'b1; #1;
    chk("up rst vld", out_vld[1], 0); chk("up rst dat", out_dat[1], 0); chk("up rst rdy", in_rdy[1], 0);
    smp();  rst = 1'b0; out_rdy[1] = 1'b1;
    tick(); in_vld[1] = 1'b1; in_dat[1] = 16'h00CB;
    tick(); in_dat[1] = 16'h00ED;
    tick(); in_vld[1] = 1'b0;
    smp();  chk("up clean vld", out_vld[1], 1); chk("up clean dat", out_dat[1], 16'hEDCB);
    tick();

    // Odd 3x3b -> 1x3b with input padding bits set.
    cur = 2; out_rdy[2] = 1'b1;
    tick(); in_vld[2] = 1'b1; in_dat[2] = 16'hFFD5;
    tick(); in_vld[2] = 1'b0;
    smp();  chk("odd e0", out_dat[2], 16'h05);
    tick(); smp(); chk("odd e1", out_dat[2], 16'h02);
    tick(); smp(); chk("odd e2", out_dat[2], 16'h07);
    tick(); smp(); chk("odd drained", out_vld[2], 0);

    // Equal width register slice with simultaneous in/out transfer.
    cur = 3; out_rdy[3] = 1'b0;
    tick(); in_vld[3] = 1'b1; in_dat[3] = 16'hBEEF;
    tick(); in_dat[3] = 16'h1234;
    smp();  chk("eq dat", out_dat[3], 16'hBEEF); chk("eq full rdy", in_rdy[3], 0);
    tick(); out_rdy[3] = 1'b1;
    smp();  chk("eq pass rdy", in_rdy[3], 1);
    tick(); in_vld[3] = 1'b0;
    smp();  chk("eq next dat", out_dat[3], 16'h1234); chk("eq next vld", out_vld[3], 1);
    tick(); smp(); chk("eq drained", out_vld[3], 0);

    for (int k = 0; k < N; k++) begin
      run_stream(k, 64, 100, 100);
      check_run($sformatf("cont%0d", k), k, 64, 1'b1);
      run_stream(k, 64, 50, 50);
      check_run($sformatf("rand%0d", k), k, 64, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
